// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl: HD44780 LCD controller with autonomous init, valid/ready byte port and tick-timed RS/E/DB
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_rs/req_data byte request port;
//   init_done, busy status; lcd_rs, lcd_rw (tied 0), lcd_e, lcd_db LCD pins.
module lcd_hd44780_ctrl #(
  parameter int TICK_DIV    = 5000,
  parameter int BUS_4BIT    = 0,
  parameter int LINES       = 4,
  parameter int COLS        = 20,
  parameter int AUTO_WRAP   = 1,
  parameter int PWRUP_TICKS = 150,
  parameter int CMD_TICKS   = 1,
  parameter int CLR_TICKS   = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);
  typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, PULSE, HOLD, WAIT} state_t;
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam logic B4 = BUS_4BIT != 0;
  localparam logic [3:0] INIT_N = B4 ? 4'd9 : 4'd5;
  // function set: DL=1 for 8-bit bus, N=1 for multi-line displays
  localparam logic [7:0] FUNC = {2'b00, 1'b1, !B4, LINES > 1, 3'b000};
  function automatic logic [6:0] base(input logic [1:0] l);
    return l == 2'd0 ? 7'h00 : l == 2'd1 ? 7'h40 : l == 2'd2 ? 7'h14 : 7'h54;
  endfunction
  // 4-bit mode prefixes three 0x3 wake-up nibbles and the 0x2 bus-width switch
  function automatic logic [7:0] init_byte(input logic [3:0] i);
    logic [3:0] k;
    k = B4 ? i - 4'd4 : i;
    if (B4 && i < 4'd3) return 8'h30;
    if (B4 && i == 4'd3) return 8'h20;
    return k == 4'd0 ? FUNC : k == 4'd1 ? 8'h08 : k == 4'd2 ? 8'h01 : k == 4'd3 ? 8'h06 : 8'h0C;
  endfunction
  state_t state_q, state_d;
  logic [TW-1:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d, wait_last;
  logic [3:0] idx_q, idx_d;
  logic [7:0] byte_q, byte_d;
  logic [1:0] line_q, line_d, hit_line, nxt_line;
  logic [5:0] col_q, col_d;
  logic rs_q, rs_d, nib_q, nib_d, single_q, single_d, done_q, done_d;
  logic tick, clr, hit, wrap;
  assign tick = div_q == TW'(TICK_DIV - 1);
  assign clr = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02);
  assign wait_last = 16'(clr ? CLR_TICKS - 1 : CMD_TICKS - 1);
  assign nxt_line = line_q == 2'(LINES - 1) ? 2'd0 : line_q + 2'd1;
  assign wrap = AUTO_WRAP != 0 && rs_q && col_q + 6'd1 == 6'(COLS);
  // set-DDRAM commands resync the tracker only when they land on a line start
  always_comb begin
    hit = 1'b0;
    hit_line = 2'd0;
    for (int k = 0; k < LINES; k++)
      if (!rs_q && byte_q[7] && byte_q[6:0] == base(2'(k))) begin
        hit = 1'b1;
        hit_line = 2'(k);
      end
  end
  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    byte_d = byte_q;
    rs_d = rs_q;
    nib_d = nib_q;
    single_d = single_q;
    done_d = done_q;
    line_d = line_q;
    col_d = col_q;
    case (state_q)
      PWRUP: if (tick) begin
        cnt_d = cnt_q == 16'(PWRUP_TICKS - 1) ? '0 : cnt_q + 16'd1;
        state_d = cnt_q == 16'(PWRUP_TICKS - 1) ? INIT : PWRUP;
      end
      INIT: begin
        byte_d = init_byte(idx_q);
        rs_d = 1'b0;
        nib_d = 1'b0;
        single_d = B4 && idx_q < 4'd4;
        state_d = SETUP;
      end
      IDLE: if (req_valid) begin
        byte_d = req_data;
        rs_d = req_rs;
        nib_d = 1'b0;
        single_d = 1'b0;
        state_d = SETUP;
      end
      SETUP: state_d = tick ? PULSE : SETUP;
      PULSE: state_d = tick ? HOLD : PULSE;
      HOLD: if (tick) begin
        nib_d = B4 && !nib_q && !single_q;
        state_d = nib_d ? SETUP : WAIT;
        cnt_d = '0;
      end
      WAIT: if (tick) begin
        if (cnt_q == wait_last) begin
          cnt_d = '0;
          if (rs_q) col_d = col_q == 6'(COLS) ? col_q : col_q + 6'd1;
          else if (clr || hit) begin
            line_d = clr ? 2'd0 : hit_line;
            col_d = '0;
          end
          if (!done_q) begin
            idx_d = idx_q + 4'd1;
            done_d = idx_q == INIT_N - 4'd1;
            state_d = done_d ? IDLE : INIT;
          end else if (wrap) begin
            byte_d = {1'b1, base(nxt_line)};
            rs_d = 1'b0;
            nib_d = 1'b0;
            single_d = 1'b0;
            state_d = SETUP;
          end else state_d = IDLE;
        end else cnt_d = cnt_q + 16'd1;
      end
      default: state_d = PWRUP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= PWRUP;
      div_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      byte_q <= '0;
      rs_q <= 1'b0;
      nib_q <= 1'b0;
      single_q <= 1'b0;
      done_q <= 1'b0;
      line_q <= '0;
      col_q <= '0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      byte_q <= byte_d;
      rs_q <= rs_d;
      nib_q <= nib_d;
      single_q <= single_d;
      done_q <= done_d;
      line_q <= line_d;
      col_q <= col_d;
    end
  assign req_ready = state_q == IDLE;
  assign busy = !req_ready;
  assign init_done = done_q;
  assign lcd_e = state_q == PULSE;
  assign lcd_rs = rs_q;
  assign lcd_rw = 1'b0;
  assign lcd_db = B4 ? {nib_q ? byte_q[3:0] : byte_q[7:4], 4'h0} : byte_q;
endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb_lcd_hd44780_ctrl: directed self-checking bench for 8-bit and 4-bit controller instances
module tb_lcd_hd44780_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vld [2], rdy [2], rs [2], done [2], bsy [2], lrs [2], lrw [2], le [2];
  logic [7:0] dat [2], db [2];
  logic [8:0] p8 [$], p4 [$];
  int c8 [$];
  int cyc;
  logic ep0, ep1;
  int n_cmp = 0, n_err = 0;
  logic [8:0] exp8 [5] = '{9'h038, 9'h008, 9'h001, 9'h006, 9'h00C};
  logic [8:0] exp4 [14] = '{9'h030, 9'h030, 9'h030, 9'h020, 9'h020, 9'h080, 9'h000,
                            9'h080, 9'h000, 9'h010, 9'h000, 9'h060, 9'h000, 9'h0C0};
  always #5 clk = ~clk;
  lcd_hd44780_ctrl #(.TICK_DIV(4)) u8 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy[0]), .req_rs(rs[0]),
    .req_data(dat[0]), .init_done(done[0]), .busy(bsy[0]), .lcd_rs(lrs[0]), .lcd_rw(lrw[0]),
    .lcd_e(le[0]), .lcd_db(db[0]));
  lcd_hd44780_ctrl #(.TICK_DIV(4), .BUS_4BIT(1)) u4 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy[1]), .req_rs(rs[1]),
    .req_data(dat[1]), .init_done(done[1]), .busy(bsy[1]), .lcd_rs(lrs[1]), .lcd_rw(lrw[1]),
    .lcd_e(le[1]), .lcd_db(db[1]));
  // log every E rising edge as {rs, db}; cyc counts clocks since reset release
  always @(negedge clk) begin
    cyc <= rst_n ? cyc + 1 : 0;
    if (le[0] && !ep0) begin
      p8.push_back({lrs[0], db[0]});
      c8.push_back(cyc);
    end
    if (le[1] && !ep1) p4.push_back({lrs[1], db[1]});
    ep0 <= le[0];
    ep1 <= le[1];
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic wait_rdy(input int s, input string tag);
    int t = 0;
    while (!rdy[s] && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check(tag, rdy[s], 1);
  endtask
  task automatic send(input int s, input logic r, input logic [7:0] d);
    vld[s] = 1'b1;
    rs[s] = r;
    dat[s] = d;
    wait_rdy(s, "hs_ready");
    @(negedge clk);
    vld[s] = 1'b0;
    wait_rdy(s, "write_done");
  endtask
  task automatic wait_init();
    int t = 0;
    while (!(done[0] && done[1]) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("init_done8", done[0], 1);
    check("init_done4", done[1], 1);
  endtask
  task automatic check_init(input int n8, input int n4);
    check("init8_cnt", p8.size() - n8, 5);
    for (int i = 0; i < 5; i++) check($sformatf("init8_%0d", i), p8[n8 + i], exp8[i]);
    check("gap_cmd", c8[n8 + 1] - c8[n8], 16);
    check("gap_clr", c8[n8 + 3] - c8[n8 + 2], 92);
    check("init4_cnt", p4.size() - n4, 14);
    for (int i = 0; i < 14; i++) check($sformatf("init4_%0d", i), p4[n4 + i], exp4[i]);
  endtask
  initial begin
    int n8, n4, t;
    logic saw;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0;
      rs[i] = 1'b0;
      dat[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("rst_e", le[0], 0);
    check("rst_db", db[0], 0);
    check("rst_ready", rdy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_busy", bsy[0], 1);
    check("rst_rw", lrw[0], 0);
    #1 rst_n = 1'b1;
    repeat (598) @(negedge clk);
    check("pwrup_no_e", p8.size(), 0);
    wait_init();
    check_init(0, 0);
    check("idle_ready", rdy[0], 1);
    check("idle_busy", bsy[0], 0);
    // held req_valid must produce exactly one write
    n8 = p8.size();
    vld[0] = 1'b1;
    rs[0] = 1'b1;
    dat[0] = 8'h42;
    wait_rdy(0, "b_hs");
    @(negedge clk);
    check("b_ready_low", rdy[0], 0);
    check("b_busy", bsy[0], 1);
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rdy[0]) saw = 1'b1;
    end
    vld[0] = 1'b0;
    check("b_held_ready", saw, 0);
    wait_rdy(0, "b_done");
    check("b_cnt", p8.size() - n8, 1);
    check("b_pulse", p8[n8], 9'h142);
    n4 = p4.size();
    send(1, 1'b1, 8'h65);
    check("d4_cnt", p4.size() - n4, 2);
    check("d4_hi", p4[n4], 9'h160);
    check("d4_lo", p4[n4 + 1], 9'h150);
    // wrap through all four lines
    send(0, 1'b0, 8'h80);
    n8 = p8.size();
    for (int i = 0; i < 80; i++) send(0, 1'b1, 8'h30 + 8'(i % 10));
    check("wrap_cnt", p8.size() - n8, 84);
    check("wrap_d19", p8[n8 + 19], 9'h139);
    check("wrap_l1", p8[n8 + 20], 9'h0C0);
    check("wrap_l2", p8[n8 + 41], 9'h094);
    check("wrap_l3", p8[n8 + 62], 9'h0D4);
    check("wrap_l0", p8[n8 + 83], 9'h080);
    // resync on line-base command, then clear
    send(0, 1'b0, 8'h94);
    n8 = p8.size();
    for (int i = 0; i < 20; i++) send(0, 1'b1, 8'h61);
    check("sync_cnt", p8.size() - n8, 21);
    check("sync_wrap", p8[n8 + 20], 9'h0D4);
    n8 = p8.size();
    send(0, 1'b0, 8'h01);
    check("clr_pulse", p8[n8], 9'h001);
    check("clr_wait", cyc - c8[n8], 88);
    n8 = p8.size();
    for (int i = 0; i < 20; i++) send(0, 1'b1, 8'h62);
    check("clr_cnt", p8.size() - n8, 21);
    check("clr_wrap", p8[n8 + 20], 9'h0C0);
    // reset while E is high
    vld[0] = 1'b1;
    rs[0] = 1'b1;
    dat[0] = 8'h55;
    wait_rdy(0, "mid_hs");
    @(negedge clk);
    vld[0] = 1'b0;
    t = 0;
    while (!le[0] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("mid_e_seen", le[0], 1);
    check("mid_db", db[0], 8'h55);
    rst_n = 1'b0;
    #1;
    check("mid_rst_e", le[0], 0);
    check("mid_rst_db", db[0], 0);
    check("mid_rst_ready", rdy[0], 0);
    check("mid_rst_done", done[0], 0);
    repeat (3) @(negedge clk);
    n8 = p8.size();
    n4 = p4.size();
    #1 rst_n = 1'b1;
    wait_init();
    check_init(n8, n4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
